// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four-requester round-robin arbiter feeding one UART
// transmitter. A requester that starts a multi-byte packet keeps ownership
// until it sends a byte marked last. Watchdogs on SEND and LOCK release the
// transmitter if it or the owner stalls.
module uart_tx_arbiter #(
    parameter int DBIT         = 8,
    parameter int TX_TIMEOUT   = 200000,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req_valid,
    input  logic [4*DBIT-1:0] req_data,
    input  logic [3:0]        req_last,
    output logic [3:0]        req_ready,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    input  logic              tx_done_tick,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic              timeout_err
);

    // One counter serves both watchdogs: SEND and LOCK never overlap and the
    // count restarts on every state change. At least 18 bits wide.
    localparam int MAX_TO = (TX_TIMEOUT > LOCK_TIMEOUT) ? TX_TIMEOUT : LOCK_TIMEOUT;
    localparam int CW_RAW = $clog2(MAX_TO + 1);
    localparam int CW     = (CW_RAW > 18) ? CW_RAW : 18;

    localparam logic [CW-1:0] TX_LIMIT   = CW'(TX_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [1:0]      ptr, ptr_next;
    logic            last_r, last_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [3:0]      ready_next;
    logic            tx_start_next;
    logic [DBIT-1:0] tx_din_next;
    logic            busy_next;
    logic [1:0]      grant_next;
    logic            timeout_next;
    logic            found;
    logic [1:0]      winner;
    logic [1:0]      idx;

    // Next-state, round-robin winner selection and next values of every
    // registered output.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next    = state;
        ptr_next      = ptr;
        last_next     = last_r;
        cnt_next      = cnt + CW'(1);
        ready_next    = 4'b0000;
        tx_start_next = tx_start;
        tx_din_next   = tx_din;
        grant_next    = grant_id;
        timeout_next  = 1'b0;
        found         = 1'b0;
        winner        = ptr;
        idx           = ptr;

        // First valid requester scanning ptr, ptr+1, ... with 2-bit wrap.
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end

        case (state)
            IDLE: begin
                cnt_next      = '0;
                tx_start_next = 1'b0;
                if (found) begin
                    state_next         = SEND;
                    tx_din_next        = req_data[int'(winner)*DBIT +: DBIT];
                    last_next          = req_last[winner];
                    ready_next[winner] = 1'b1;
                    grant_next         = winner;
                    tx_start_next      = 1'b1;
                end
            end

            SEND: begin
                tx_start_next = 1'b1;
                // A done tick beats a simultaneous watchdog expiry.
                if (tx_done_tick) begin
                    tx_start_next = 1'b0;
                    cnt_next      = '0;
                    if (last_r) begin
                        state_next = IDLE;
                        ptr_next   = grant_id + 2'd1;
                    end else begin
                        state_next = LOCK;
                    end
                end else if (cnt == TX_LIMIT) begin
                    timeout_next  = 1'b1;
                    tx_start_next = 1'b0;
                    cnt_next      = '0;
                    state_next    = IDLE;
                    ptr_next      = grant_id + 2'd1;
                end
            end

            LOCK: begin
                // Only the owner is considered; done ticks are ignored here.
                tx_start_next = 1'b0;
                if (req_valid[grant_id]) begin
                    state_next           = SEND;
                    tx_din_next          = req_data[int'(grant_id)*DBIT +: DBIT];
                    last_next            = req_last[grant_id];
                    ready_next[grant_id] = 1'b1;
                    tx_start_next        = 1'b1;
                    cnt_next             = '0;
                end else if (cnt == LOCK_LIMIT) begin
                    timeout_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = IDLE;
                    ptr_next     = grant_id + 2'd1;
                end
            end

            default: begin
                state_next    = IDLE;
                tx_start_next = 1'b0;
                cnt_next      = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State, pointer, watchdog counter and all outputs, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the
        // same pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            last_r      <= 1'b0;
            cnt         <= '0;
            req_ready   <= 4'b0000;
            tx_start    <= 1'b0;
            tx_din      <= '0;
            busy        <= 1'b0;
            grant_id    <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            last_r      <= last_next;
            cnt         <= cnt_next;
            req_ready   <= ready_next;
            tx_start    <= tx_start_next;
            tx_din      <= tx_din_next;
            busy        <= busy_next;
            grant_id    <= grant_next;
            timeout_err <= timeout_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with short watchdogs (TX 16, LOCK 8).
// Outputs are sampled and inputs driven on the falling edge.
module tb_uart_tx_arbiter;

    localparam int DBIT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [4*DBIT-1:0] req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic            tx_start;
    logic [DBIT-1:0] tx_din;
    logic            tx_done_tick;
    logic            busy;
    logic [1:0]      grant_id;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .DBIT        (DBIT),
        .TX_TIMEOUT  (16),
        .LOCK_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_din      (tx_din),
        .tx_done_tick(tx_done_tick),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_valid    = 4'b0000;
        req_data     = '0;
        req_last     = 4'b0000;
        tx_done_tick = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // One-cycle done pulse from the transmitter.
    task automatic finish_byte();
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
    endtask

    // Hard stop if the sequence below ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_din", tx_din, 0);
        check("rst_timeout", timeout_err, 0);

        // Single byte from requester 0
        req_valid = 4'b0001; req_data[7:0] = 8'h55; req_last = 4'b0001;
        tick(1);
        check("single_ready", req_ready, 4'b0001);
        check("single_start", tx_start, 1);
        check("single_din", tx_din, 8'h55);
        check("single_busy", busy, 1);
        check("single_grant", grant_id, 0);
        req_valid = 4'b0000;
        tick(1);
        check("single_ready_once", req_ready, 0);
        check("single_start_hold", tx_start, 1);
        tick(2);
        finish_byte();
        check("single_start_drop", tx_start, 0);
        check("single_idle", busy, 0);
        // Pointer is now 1: requester 1 beats requester 0
        req_valid = 4'b0011; req_last = 4'b0011;
        req_data[7:0] = 8'h10; req_data[15:8] = 8'h11;
        tick(1);
        check("ptr1_grant", grant_id, 1);
        check("ptr1_ready", req_ready, 4'b0010);
        check("ptr1_din", tx_din, 8'h11);

        // Round robin with all four always valid
        do_reset();
        req_valid = 4'b1111; req_last = 4'b1111;
        req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int i = 0; i < 5; i++) begin
            int e;
            e = i % 4;
            tick(1);
            check("rr_grant", grant_id, e);
            check("rr_ready", req_ready, 32'(1 << e));
            check("rr_din", tx_din, 32'(8'h30 + e));
            tick(2);
            finish_byte();
            check("rr_gap", tx_start, 0);
        end

        // Packet lock: requester 2 sends A1 (not last), then A2 (last)
        do_reset();
        req_valid = 4'b0100; req_data[23:16] = 8'hA1; req_last = 4'b0000;
        tick(1);
        check("lock_first_grant", grant_id, 2);
        check("lock_first_ready", req_ready, 4'b0100);
        check("lock_first_din", tx_din, 8'hA1);
        req_valid = 4'b0001; req_data[7:0] = 8'h0F; req_last = 4'b0001;
        tick(1);
        finish_byte();
        check("lock_gap_start", tx_start, 0);
        check("lock_busy", busy, 1);
        check("lock_grant_hold", grant_id, 2);
        check("lock_no_ready", req_ready, 0);
        // Done tick while locked is ignored
        finish_byte();
        check("lock_done_ignored_busy", busy, 1);
        check("lock_done_ignored_ready", req_ready, 0);
        check("lock_done_ignored_start", tx_start, 0);
        req_valid = 4'b0101; req_data[23:16] = 8'hA2; req_last = 4'b0101;
        tick(1);
        check("lock_second_ready", req_ready, 4'b0100);
        check("lock_second_din", tx_din, 8'hA2);
        check("lock_second_start", tx_start, 1);
        req_valid = 4'b0001;
        tick(1);
        finish_byte();
        check("lock_release_busy", busy, 0);
        tick(1);
        check("lock_after_grant", grant_id, 0);
        check("lock_after_ready", req_ready, 4'b0001);
        check("lock_after_din", tx_din, 8'h0F);

        // TX watchdog: no done tick for 16 SEND cycles
        do_reset();
        req_valid = 4'b0010; req_data[15:8] = 8'h77; req_last = 4'b0010;
        tick(1);
        req_valid = 4'b0000;
        tick(15);
        check("txwd_cycle16_start", tx_start, 1);
        check("txwd_cycle16_noerr", timeout_err, 0);
        tick(1);
        check("txwd_err", timeout_err, 1);
        check("txwd_start_drop", tx_start, 0);
        check("txwd_idle", busy, 0);
        req_valid = 4'b0110; req_last = 4'b0110;
        req_data[15:8] = 8'h61; req_data[23:16] = 8'h62;
        tick(1);
        check("txwd_err_pulse", timeout_err, 0);
        check("txwd_ptr_grant", grant_id, 2);
        check("txwd_ptr_din", tx_din, 8'h62);

        // Done tick and TX expiry together: done wins
        do_reset();
        req_valid = 4'b1000; req_data[31:24] = 8'h88; req_last = 4'b1000;
        tick(1);
        req_valid = 4'b0000;
        tick(15);
        finish_byte();
        check("coll_noerr", timeout_err, 0);
        check("coll_idle", busy, 0);
        check("coll_start", tx_start, 0);
        req_valid = 4'b1001; req_last = 4'b1001; req_data[7:0] = 8'h01;
        tick(1);
        check("coll_wrap_grant", grant_id, 0);

        // LOCK watchdog: owner 1 sends last=0 then goes silent
        do_reset();
        req_valid = 4'b0010; req_data[15:8] = 8'h21; req_last = 4'b0000;
        tick(1);
        req_valid = 4'b0000;
        tick(1);
        finish_byte();
        check("lkwd_locked", busy, 1);
        tick(7);
        check("lkwd_cycle8_noerr", timeout_err, 0);
        check("lkwd_cycle8_busy", busy, 1);
        tick(1);
        check("lkwd_err", timeout_err, 1);
        check("lkwd_idle", busy, 0);
        req_valid = 4'b0110; req_last = 4'b0110;
        req_data[15:8] = 8'h61; req_data[23:16] = 8'h62;
        tick(1);
        check("lkwd_ptr_grant", grant_id, 2);

        // Reset asserted mid-SEND
        do_reset();
        req_valid = 4'b0001; req_data[7:0] = 8'h5A; req_last = 4'b0001;
        tick(2);
        reset = 1'b1; req_valid = 4'b0000;
        tick(1);
        check("rsend_start", tx_start, 0);
        check("rsend_busy", busy, 0);
        check("rsend_ready", req_ready, 0);
        check("rsend_err", timeout_err, 0);
        reset = 1'b0;
        req_valid = 4'b1000; req_data[31:24] = 8'h99; req_last = 4'b1000;
        tick(1);
        check("rsend_grant3", grant_id, 3);
        check("rsend_ready3", req_ready, 4'b1000);
        check("rsend_din3", tx_din, 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
